// File: rtl/cpu_step_ctrl_if.sv
// rtl/cpu_step_ctrl_if.sv - button, mode and CPU-side signals of the step controller
interface cpu_step_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             btn_step;
  logic             btn_run;
  logic [1:0]       mode;
  logic [7:0]       burst_len;
  logic [31:0]      pc;
  logic [31:0]      bp_addr;
  logic             cpu_ce;
  logic             busy;
  logic             halted;
  logic [2:0]       state;
  logic [CNT_W-1:0] step_cnt;

  modport master (
    input  btn_step, btn_run, mode, burst_len, pc, bp_addr,
    output cpu_ce, busy, halted, state, step_cnt
  );

  modport slave (
    output btn_step, btn_run, mode, burst_len, pc, bp_addr,
    input  cpu_ce, busy, halted, state, step_cnt
  );
endinterface

// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - CPU clock-enable sequencer: single-step, burst, prescaled free-run
// Optional PC breakpoint halt enabled by defining CPU_BREAKPOINT_EN.
module cpu_step_ctrl #(
  parameter int DIV   = 50_000_000,
  parameter int CNT_W = 32
) (
  input  logic            clk_100MHz,
  input  logic            rst,
  cpu_step_ctrl_if.master bus
);
  localparam int PW = $clog2(DIV);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STEP  = 3'd1,
    S_BURST = 3'd2,
    S_RUN   = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             cpu_ce_q, cpu_ce_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [8:0]       burst_q, burst_d;
  logic             btn_step_q, btn_step_d;
  logic             btn_run_q, btn_run_d;
  logic             step_edge, run_edge;
  logic             bp_hit;

`ifdef CPU_BREAKPOINT_EN
  assign bp_hit     = (bus.pc == bus.bp_addr);
  assign bus.halted = (state_q == S_HALT);
`else
  logic unused_bp;
  assign unused_bp  = ^{bus.pc, bus.bp_addr};
  assign bp_hit     = 1'b0;
  assign bus.halted = 1'b0;
`endif

  always_comb begin
    step_edge  = bus.btn_step & ~btn_step_q;
    run_edge   = bus.btn_run & ~btn_run_q;
    state_d    = state_q;
    cpu_ce_d   = 1'b0;
    presc_d    = presc_q;
    burst_d    = burst_q;
    btn_step_d = bus.btn_step;
    btn_run_d  = bus.btn_run;
    step_cnt_d = step_cnt_q + CNT_W'(cpu_ce_q);

    // cpu_ce_d is the pulse decision; the pulse itself appears one cycle later
    unique case (state_q)
      S_IDLE: begin
        if (step_edge) begin
          if (bus.mode == 2'b01) begin
            state_d = S_BURST;
            burst_d = (bus.burst_len == 8'd0) ? 9'd256 : {1'b0, bus.burst_len};
          end else if (bus.mode != 2'b10) begin
            state_d = S_STEP;
          end
        end else if (run_edge && bus.mode == 2'b10) begin
          state_d = S_RUN;
          presc_d = '0;
        end
      end
      S_STEP: begin
        cpu_ce_d = 1'b1;
        state_d  = S_IDLE;
      end
      S_BURST: begin
        if (bp_hit) begin
          state_d = S_HALT;
        end else begin
          cpu_ce_d = 1'b1;
          burst_d  = burst_q - 9'd1;
          if (burst_q == 9'd1) state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (run_edge) begin
          state_d = S_IDLE;
        end else if (presc_q == PW'(DIV - 1)) begin
          presc_d = '0;
          if (bp_hit) state_d = S_HALT;
          else        cpu_ce_d = 1'b1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      S_HALT: begin
        if (step_edge)     state_d = S_STEP;
        else if (run_edge) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cpu_ce_q   <= 1'b0;
      step_cnt_q <= '0;
      presc_q    <= '0;
      burst_q    <= '0;
      btn_step_q <= 1'b1;
      btn_run_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      cpu_ce_q   <= cpu_ce_d;
      step_cnt_q <= step_cnt_d;
      presc_q    <= presc_d;
      burst_q    <= burst_d;
      btn_step_q <= btn_step_d;
      btn_run_q  <= btn_run_d;
    end
  end

  // Masking with rst keeps a pending pulse off the core during the reset cycle
  assign bus.cpu_ce   = cpu_ce_q & ~rst;
  assign bus.busy     = (state_q == S_BURST) || (state_q == S_RUN);
  assign bus.state    = state_q;
  assign bus.step_cnt = step_cnt_q;
endmodule
